present_decryptor_top: RTL and testbench
========================================

Name: present_decryptor_top

Overview:
Iterative PRESENT-80 decryption core, the inverse of present_encryptor_top. It shares the same loading interface: a key load followed by a ciphertext load on one wide input bus, one round per clock. The core first runs the key schedule forward to derive the last round key, then executes the 31 inverse rounds with an on-the-fly inverse key schedule. It is the receive-side counterpart in the encryption core pair.

Parameters:
ROUNDS, 31, number of cipher rounds; the standard test vectors are valid only at 31.
KEY_W, 80, key width; fixed at 80 in this revision.
DATA_W, 64, block width.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
data_i  input  80  key when key_load=1; ciphertext in bits [63:0] when data_load=1
key_load  input  1  sample data_i as key and start key expansion
data_load  input  1  sample data_i[63:0] as ciphertext and start decryption
data_o  output  64  plaintext; holds the last result
key_ready_o  output  1  last round key available; data_load is accepted
busy_o  output  1  key expansion or decryption in progress
valid_o  output  1  one-cycle pulse when data_o is updated

Behaviour:
- Reset: data_o=0, valid_o=0, key_ready_o=0, busy_o=0, FSM=IDLE, all internal key and state registers=0.
- FSM states: IDLE, KEY_EXP, KEY_RDY, DECRYPT.
- key_load (any state): key_reg<=data_i; rc<=1; go to KEY_EXP; key_ready_o<=0; busy_o<=1.
- KEY_EXP, per cycle: key_reg<=fwd(key_reg, rc); rc++.
  - fwd: rotate left 61; S-box on bits [79:76]; bits [19:15] ^= rc.
  - After 31 updates (rc=31 applied): kfin<=fwd result; go to KEY_RDY; key_ready_o=1; busy_o=0.
- Key expansion takes 31 cycles from the key_load edge.
- data_load in KEY_RDY: st<=data_i[63:0]^kfin[79:16]; kw<=kfin; rc<=31; go to DECRYPT; busy_o=1.
- DECRYPT, per cycle:
  - kn=inv(kw, rc): bits [19:15]^=rc; inverse S-box on [79:76]; rotate right 61.
  - st<=invS(invP(st))^kn[79:16]; kw<=kn; rc--.
  - invP: bit j of the output takes bit P(j) of the input, where P(i)=16*i mod 63 (P(63)=63).
  - invS table: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Completion: the edge that applies rc=1 (31st cycle after the data_load edge) writes the final value to data_o. valid_o is high the following cycle only. FSM returns to KEY_RDY and busy_o falls.
- kfin is retained, so further data_load pulses reuse the key without re-expansion.
- data_load in IDLE or KEY_EXP: ignored.
- data_load in DECRYPT: ignored (default build).
- key_load and data_load in the same cycle: key_load wins, data_load dropped.
- key_load during DECRYPT: aborts the operation; data_o keeps its old value; no valid_o pulse.
- rst_i mid-operation: immediate return to the reset values on that edge.
- The data_load pulse width may exceed one cycle. Only the KEY_RDY edge is acted on; a level still high after completion starts a new decryption.

Optional Feature:
PRESENT_DEC_PREEMPT_EN:
- Defined: data_load during DECRYPT restarts decryption with the new ciphertext (st, kw, rc reloaded as in KEY_RDY). The aborted result is discarded; there is no valid_o pulse for it.
- Undefined: data_load during DECRYPT is ignored, as in the default build.

Test Plan:
- Reset, then key_load with key 0. 31 cycles later key_ready_o=1. data_load with ct 5579C1387B228445 → valid_o 31 cycles after load; data_o=0000000000000000.
- Key FFFFFFFFFFFFFFFFFFFF, ct E72C46C0F5945049 → data_o=0000000000000000. Key 0, ct A112FFC72F68417B → data_o=FFFFFFFFFFFFFFFF. Key all-F, ct 3333DCD3213210D2 → data_o=FFFFFFFFFFFFFFFF.
- Key reuse: after one decryption with key 0, a second data_load with no new key_load, ct A112FFC72F68417B → FFFFFFFFFFFFFFFF.
- data_load during KEY_EXP, and data_load together with key_load → both ignored; no valid_o; FSM still reaches KEY_RDY 31 cycles after key_load.
- key_load at cycle 10 of DECRYPT → no valid_o; data_o unchanged; key_ready_o=0 for 31 cycles, then 1.
- rst_i at cycle 15 of DECRYPT → all outputs 0 next cycle; subsequent data_load ignored until a new key is loaded.
- PRESENT_DEC_PREEMPT_EN defined, key 0: load ct 5579C1387B228445, then at cycle 5 load ct A112FFC72F68417B → a single valid_o, 31 cycles after the second load; data_o=FFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/present_decryptor_top.sv
// -----------------------------------------------------------------------------
// present_decryptor_top
//
// Iterative PRESENT-80 decryption core, one round per clock.
// A key load runs the key schedule forward for 31 cycles to reach the last
// round key (kfin). Each ciphertext load then runs the 31 inverse rounds. The
// round keys are rebuilt on the fly by an inverse key schedule seeded with kfin.
// kfin is kept, so later ciphertexts reuse the expanded key.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   data_i       key (80 bits) on key_load, ciphertext in [63:0] on data_load
//   key_load     sample data_i as key, start key expansion (always wins)
//   data_load    sample data_i[63:0] as ciphertext, start decryption
//   data_o       plaintext, holds the last completed result
//   key_ready_o  last round key available, data_load accepted
//   busy_o       key expansion or decryption in progress
//   valid_o      one-cycle pulse when data_o is updated
//
// Build option:
//   PRESENT_DEC_PREEMPT_EN  when defined, data_load during decryption restarts
//                           it with the new ciphertext. The interrupted result
//                           is dropped.
// -----------------------------------------------------------------------------
module present_decryptor_top #(
   parameter int unsigned ROUNDS = 31,
   parameter int unsigned KEY_W  = 80,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [KEY_W-1:0]  data_i,
   input  logic              key_load,
   input  logic              data_load,
   output logic [DATA_W-1:0] data_o,
   output logic              key_ready_o,
   output logic              busy_o,
   output logic              valid_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_KEY_EXP = 2'd1,
      S_KEY_RDY = 2'd2,
      S_DECRYPT = 2'd3
   } state_e;

   localparam logic [4:0] LAST_RC  = 5'(ROUNDS);
   localparam logic [4:0] FIRST_RC = 5'd1;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   // Inverse bit permutation: output bit j comes from input bit 16*j mod 63.
   function automatic logic [63:0] inv_player(input logic [63:0] x);
      logic [63:0] y;
      y = 64'h0;
      for (int j = 0; j < 63; j++) begin
         y[6'(j)] = x[6'((j * 16) % 63)];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] inv_slayer(input logic [63:0] x);
      logic [63:0] y;
      y = 64'h0;
      for (int n = 0; n < 16; n++) begin
         y[6'(4 * n) +: 4] = inv_sbox(x[6'(4 * n) +: 4]);
      end
      return y;
   endfunction

   // Forward key update: rotate left 61, S-box on the top nibble, mix in rc.
   function automatic logic [79:0] fwd_key(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] r;
      r          = {k[18:0], k[79:19]};
      r[79:76]   = sbox(r[79:76]);
      r[19:15]   = r[19:15] ^ rc;
      return r;
   endfunction

   // Exact inverse of fwd_key: undo rc mix, inverse S-box, rotate right 61.
   function automatic logic [79:0] inv_key(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] r;
      r          = k;
      r[19:15]   = r[19:15] ^ rc;
      r[79:76]   = inv_sbox(r[79:76]);
      return {r[60:0], r[79:61]};
   endfunction

   state_e      state_q, state_d;
   logic [79:0] key_q, key_d;        // working key: expansion register, then kw
   logic [79:0] kfin_q, kfin_d;      // last round key, kept across decryptions
   logic [63:0] st_q, st_d;
   logic [4:0]  rc_q, rc_d;
   logic [63:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        key_ready_q, key_ready_d;
   logic        busy_q, busy_d;

   logic [79:0] fwd_key_s;
   logic [79:0] inv_key_s;
   logic [63:0] round_s;
   logic        do_load_s;

   assign fwd_key_s = fwd_key(key_q, rc_q);
   assign inv_key_s = inv_key(key_q, rc_q);
   assign round_s   = inv_slayer(inv_player(st_q)) ^ inv_key_s[79:16];

`ifdef PRESENT_DEC_PREEMPT_EN
   assign do_load_s = data_load && ((state_q == S_KEY_RDY) || (state_q == S_DECRYPT));
`else
   assign do_load_s = data_load && (state_q == S_KEY_RDY);
`endif

   // State register and datapath registers, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         key_q       <= 80'h0;
         kfin_q      <= 80'h0;
         st_q        <= 64'h0;
         rc_q        <= 5'd0;
         data_q      <= 64'h0;
         valid_q     <= 1'b0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         kfin_q      <= kfin_d;
         st_q        <= st_d;
         rc_q        <= rc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and datapath update; key_load has priority over everything.
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      kfin_d      = kfin_q;
      st_d        = st_q;
      rc_d        = rc_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      key_ready_d = key_ready_q;
      busy_d      = busy_q;
      if (key_load) begin
         key_d       = data_i;
         rc_d        = FIRST_RC;
         state_d     = S_KEY_EXP;
         key_ready_d = 1'b0;
         busy_d      = 1'b1;
      end else if (do_load_s) begin
         st_d    = data_i[63:0] ^ kfin_q[79:16];
         key_d   = kfin_q;
         rc_d    = LAST_RC;
         state_d = S_DECRYPT;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_KEY_EXP: begin
               key_d = fwd_key_s;
               rc_d  = rc_q + 5'd1;
               if (rc_q == LAST_RC) begin
                  kfin_d      = fwd_key_s;
                  state_d     = S_KEY_RDY;
                  key_ready_d = 1'b1;
                  busy_d      = 1'b0;
               end else begin
                  state_d = S_KEY_EXP;
               end
            end
            S_KEY_RDY: begin
               state_d = S_KEY_RDY;
            end
            S_DECRYPT: begin
               st_d  = round_s;
               key_d = inv_key_s;
               rc_d  = rc_q - 5'd1;
               // rc=1 is the final round: the state is now the plaintext.
               if (rc_q == FIRST_RC) begin
                  data_d  = round_s;
                  valid_d = 1'b1;
                  state_d = S_KEY_RDY;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_DECRYPT;
               end
            end
            default: begin
               state_d     = S_IDLE;
               key_ready_d = 1'b0;
               busy_d      = 1'b0;
            end
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign key_ready_o = key_ready_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_present_decryptor_top.sv
module tb_present_decryptor_top;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [79:0] data_i;
   logic        key_load;
   logic        data_load;
   logic [63:0] data_o;
   logic        key_ready_o;
   logic        busy_o;
   logic        valid_o;

   int checks = 0;
   int errors = 0;

   localparam logic [79:0] KEY_0 = 80'h0000_0000_0000_0000_0000;
   localparam logic [79:0] KEY_F = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] PT_0  = 64'h0000_0000_0000_0000;
   localparam logic [63:0] PT_F  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] CT_00 = 64'h5579_C138_7B22_8445; // key 0, pt 0
   localparam logic [63:0] CT_F0 = 64'hE72C_46C0_F594_5049; // key F, pt 0
   localparam logic [63:0] CT_0F = 64'hA112_FFC7_2F68_417B; // key 0, pt F
   localparam logic [63:0] CT_FF = 64'h3333_DCD3_2132_10D2; // key F, pt F

   present_decryptor_top dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .data_i      (data_i),
      .key_load    (key_load),
      .data_load   (data_load),
      .data_o      (data_o),
      .key_ready_o (key_ready_o),
      .busy_o      (busy_o),
      .valid_o     (valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive a one-cycle key_load; returns just after the load edge.
   task automatic pulse_key(input logic [79:0] k);
      data_i   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   // Drive a one-cycle data_load; returns just after the load edge.
   task automatic pulse_data(input logic [63:0] ct);
      data_i    = {16'h0, ct};
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
   endtask

   // Sample, then advance, n times; counts cycles with valid_o / key_ready_o high.
   task automatic run_cycles(input int n, output int vcnt, output int kcnt);
      vcnt = 0;
      kcnt = 0;
      for (int i = 0; i < n; i++) begin
         if (valid_o === 1'b1) vcnt++;
         if (key_ready_o === 1'b1) kcnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; key_load = 1'b0; data_load = 1'b0; data_i = 80'h0;
      tick(); tick();
      rst_i = 1'b0;
      checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data_o got %h want %h", data_o, 64'h0); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
      checks++; if (key_ready_o !== 1'b0) begin errors++; $display("FAIL reset_key_ready got %b want 0", key_ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
   endtask

   task automatic test_vectors();
      logic [79:0] keys [4];
      logic [63:0] cts  [4];
      logic [63:0] pts  [4];
      int vc, kc;
      keys[0] = KEY_0; cts[0] = CT_00; pts[0] = PT_0;
      keys[1] = KEY_F; cts[1] = CT_F0; pts[1] = PT_0;
      keys[2] = KEY_0; cts[2] = CT_0F; pts[2] = PT_F;
      keys[3] = KEY_F; cts[3] = CT_FF; pts[3] = PT_F;
      for (int v = 0; v < 4; v++) begin
         pulse_key(keys[v]);
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL vec%0d_busy_kexp got %b want 1", v, busy_o); end
         run_cycles(31, vc, kc);
         checks++; if (kc !== 0) begin errors++; $display("FAIL vec%0d_key_ready_early got %0d cycles want 0", v, kc); end
         checks++; if (key_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL vec%0d_key_ready got rdy=%b busy=%b want 1/0", v, key_ready_o, busy_o); end
         pulse_data(cts[v]);
         run_cycles(31, vc, kc);
         checks++; if (vc !== 0) begin errors++; $display("FAIL vec%0d_valid_early got %0d want 0", v, vc); end
         checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL vec%0d_valid got %b want 1", v, valid_o); end
         checks++; if (data_o !== pts[v]) begin errors++; $display("FAIL vec%0d_data got %h want %h", v, data_o, pts[v]); end
         tick();
         checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL vec%0d_after got valid=%b busy=%b want 0/0", v, valid_o, busy_o); end
      end
   endtask

   task automatic test_key_reuse();
      int vc, kc;
      pulse_key(KEY_0);
      run_cycles(31, vc, kc);
      pulse_data(CT_00);
      run_cycles(31, vc, kc);
      checks++; if (valid_o !== 1'b1 || data_o !== PT_0) begin errors++; $display("FAIL reuse_first got valid=%b data=%h want 1/%h", valid_o, data_o, PT_0); end
      tick();
      pulse_data(CT_0F);
      run_cycles(31, vc, kc);
      checks++; if (valid_o !== 1'b1 || data_o !== PT_F) begin errors++; $display("FAIL reuse_second got valid=%b data=%h want 1/%h", valid_o, data_o, PT_F); end
      tick();
   endtask

   // Entry: key 0 ready, data_o = all ones from the previous test.
   task automatic test_abort();
      int vc, kc, vc2, kc2;
      pulse_data(CT_00);
      run_cycles(9, vc, kc);
      data_i = KEY_F; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      run_cycles(31, vc2, kc2);
      checks++; if (vc + vc2 !== 0) begin errors++; $display("FAIL abort_valid got %0d pulses want 0", vc + vc2); end
      checks++; if (kc2 !== 0) begin errors++; $display("FAIL abort_key_ready_early got %0d want 0", kc2); end
      checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL abort_key_ready got %b want 1", key_ready_o); end
      checks++; if (data_o !== PT_F) begin errors++; $display("FAIL abort_data_held got %h want %h", data_o, PT_F); end
      pulse_data(CT_F0);
      run_cycles(31, vc, kc);
      checks++; if (valid_o !== 1'b1 || data_o !== PT_0) begin errors++; $display("FAIL abort_newkey got valid=%b data=%h want 1/%h", valid_o, data_o, PT_0); end
      tick();
   endtask

   // Entry: key F ready. Loads key 0 together with data_load, then pokes data_load during expansion.
   task automatic test_ignored_loads();
      int vc, kc, vt, kt;
      data_i = KEY_0; key_load = 1'b1; data_load = 1'b1;
      tick();
      key_load = 1'b0; data_load = 1'b0;
      checks++; if (key_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL both_loads got rdy=%b busy=%b want 0/1", key_ready_o, busy_o); end
      run_cycles(10, vc, kc); vt = vc; kt = kc;
      data_i = {16'h0, CT_00}; data_load = 1'b1;
      run_cycles(1, vc, kc); vt += vc; kt += kc;
      data_load = 1'b0;
      run_cycles(20, vc, kc); vt += vc; kt += kc;
      checks++; if (vt !== 0 || kt !== 0) begin errors++; $display("FAIL ignored_during_kexp got valid=%0d rdy=%0d want 0/0", vt, kt); end
      checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL ignored_key_ready got %b want 1", key_ready_o); end
      pulse_data(CT_0F);
      run_cycles(31, vc, kc);
      checks++; if (valid_o !== 1'b1 || data_o !== PT_F) begin errors++; $display("FAIL ignored_then_decrypt got valid=%b data=%h want 1/%h", valid_o, data_o, PT_F); end
      tick();
   endtask

   // Entry: key 0 ready. Second data_load arrives at cycle 5 of decryption.
   task automatic test_second_load();
      int vc, kc, vt;
      pulse_data(CT_00);
      run_cycles(5, vc, kc); vt = vc;
      data_i = {16'h0, CT_0F}; data_load = 1'b1;
      run_cycles(1, vc, kc); vt += vc;
      data_load = 1'b0;
`ifdef PRESENT_DEC_PREEMPT_EN
      run_cycles(31, vc, kc); vt += vc;
      checks++; if (vt !== 0) begin errors++; $display("FAIL preempt_stray_valid got %0d want 0", vt); end
      checks++; if (valid_o !== 1'b1 || data_o !== PT_F) begin errors++; $display("FAIL preempt_result got valid=%b data=%h want 1/%h", valid_o, data_o, PT_F); end
`else
      run_cycles(25, vc, kc); vt += vc;
      checks++; if (vt !== 0) begin errors++; $display("FAIL nopreempt_stray_valid got %0d want 0", vt); end
      checks++; if (valid_o !== 1'b1 || data_o !== PT_0) begin errors++; $display("FAIL nopreempt_result got valid=%b data=%h want 1/%h", valid_o, data_o, PT_0); end
`endif
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL second_load_single_pulse got %b want 0", valid_o); end
   endtask

   // Entry: key 0 ready. data_load held high across a completion.
   task automatic test_back_to_back();
      int vc, kc;
      data_i = {16'h0, CT_00}; data_load = 1'b1;
      tick();
      run_cycles(31, vc, kc);
      checks++; if (vc !== 0 || valid_o !== 1'b1 || data_o !== PT_0) begin errors++; $display("FAIL b2b_first got early=%0d valid=%b data=%h want 0/1/%h", vc, valid_o, data_o, PT_0); end
      tick();
      data_load = 1'b0;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_restart got valid=%b busy=%b want 0/1", valid_o, busy_o); end
      run_cycles(31, vc, kc);
      checks++; if (vc !== 0 || valid_o !== 1'b1 || data_o !== PT_0) begin errors++; $display("FAIL b2b_second got early=%0d valid=%b data=%h want 0/1/%h", vc, valid_o, data_o, PT_0); end
      tick();
   endtask

   // Entry: key 0 ready.
   task automatic test_reset_mid();
      int vc, kc;
      pulse_data(CT_0F);
      run_cycles(14, vc, kc);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      checks++; if (data_o !== 64'h0 || valid_o !== 1'b0 || key_ready_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL rst_mid got data=%h valid=%b rdy=%b busy=%b want all 0", data_o, valid_o, key_ready_o, busy_o);
      end
      pulse_data(CT_0F);
      run_cycles(35, vc, kc);
      checks++; if (vc !== 0 || kc !== 0 || busy_o !== 1'b0 || data_o !== 64'h0) begin
         errors++; $display("FAIL rst_then_load got valid=%0d rdy=%0d busy=%b data=%h want 0/0/0/0", vc, kc, busy_o, data_o);
      end
   endtask

   initial begin
      rst_i = 1'b1; key_load = 1'b0; data_load = 1'b0; data_i = 80'h0;
      test_reset();
      test_vectors();
      test_key_reuse();
      test_abort();
      test_ignored_loads();
      test_second_load();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
